// File: rtl/ws2811_frame_streamer.sv
// Pixel RAM to WS2811 bit-stream sequencer: fetch, serialise MSB-first, latch gap.
// Define WS2811_GRB_ORDER_EN to emit G,R,B from R,G,B-ordered RAM.
module ws2811_frame_streamer #(
  parameter int NUM_LEDS   = 50,
  parameter int ADDR_W     = 12,
  parameter int GAP_CYCLES = 2600
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int CW = 13;
  localparam logic [CW-1:0] NB = CW'(3 * NUM_LEDS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  function automatic logic [1:0] byte_off(input logic [1:0] sub);
`ifdef WS2811_GRB_ORDER_EN
    byte_off = (sub == 2'd0) ? 2'd1 : (sub == 2'd1) ? 2'd0 : sub;
`else
    byte_off = sub;
`endif
  endfunction

  logic [1:0]        state;
  logic [7:0]        shift;
  logic [7:0]        hold;
  logic              shift_full;
  logic              hold_full;
  logic [2:0]        bit_cnt;
  logic [CW-1:0]     byte_cnt;
  logic [CW-1:0]     f_cnt;
  logic [ADDR_W-1:0] f_pix;
  logic [1:0]        f_sub;
  logic              rd_s1;
  logic              rd_s2;
  logic [GW-1:0]     gap_cnt;

  logic              xfer;
  logic              last_bit;
  logic              need;
  logic              issue;
  logic [ADDR_W-1:0] fetch_base;
  logic [1:0]        fetch_sub;

  assign bit_valid  = (state == S_SHIFT) && shift_full;
  assign bit_out    = bit_valid & shift[7];
  assign frame_done = (state == S_GAP) && (gap_cnt == GAP_LAST);
  assign busy       = (state != S_IDLE) && !frame_done;
  assign xfer       = bit_valid && bit_ready;
  assign last_bit   = xfer && (bit_cnt == 3'd7);
  assign need       = !shift_full || last_bit;

  always_comb begin
    issue = 1'b0;
    unique case (1'b1)
      state == S_IDLE:  issue = start;
      state == S_PRIME: issue = rd_s2;
      state == S_SHIFT: issue = last_bit && (f_cnt != NB);
      default:          issue = 1'b0;
    endcase
    fetch_base = (state == S_IDLE) ? frame_base : f_pix;
    fetch_sub  = (state == S_IDLE) ? 2'd0 : f_sub;
  end

  // Fetch side: one read per consumed byte keeps at most one byte queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      f_pix    <= '0;
      f_sub    <= '0;
      f_cnt    <= '0;
      rd_s1    <= 1'b0;
      rd_s2    <= 1'b0;
    end else begin
      rd_s1 <= issue;
      rd_s2 <= rd_s1;
      if (issue) begin
        ram_addr <= fetch_base + ADDR_W'(byte_off(fetch_sub));
        f_cnt    <= (state == S_IDLE) ? CW'(1) : f_cnt + CW'(1);
        if (fetch_sub == 2'd2) begin
          f_sub <= 2'd0;
          f_pix <= fetch_base + ADDR_W'(3);
        end else begin
          f_sub <= fetch_sub + 2'd1;
          f_pix <= fetch_base;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shift      <= '0;
      hold       <= '0;
      shift_full <= 1'b0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (start) state <= S_PRIME;
        end
        state == S_PRIME: begin
          if (rd_s2) begin
            shift      <= ram_data;
            shift_full <= 1'b1;
            hold_full  <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            state      <= S_SHIFT;
          end
        end
        state == S_SHIFT: begin
          if (xfer) begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (last_bit) byte_cnt <= byte_cnt + CW'(1);
          if (last_bit && (byte_cnt == NB - CW'(1))) begin
            shift_full <= 1'b0;
            hold_full  <= 1'b0;
            gap_cnt    <= '0;
            state      <= S_GAP;
          end else if (need) begin
            // Holding byte goes straight in; otherwise take RAM data as it lands.
            if (hold_full) begin
              shift      <= hold;
              shift_full <= 1'b1;
              hold_full  <= rd_s2;
              if (rd_s2) hold <= ram_data;
            end else if (rd_s2) begin
              shift      <= ram_data;
              shift_full <= 1'b1;
            end else begin
              shift_full <= 1'b0;
            end
          end else if (rd_s2) begin
            hold      <= ram_data;
            hold_full <= 1'b1;
          end
        end
        default: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_frame_streamer.sv
// Randomised bench for ws2811_frame_streamer against a byte-order/bit-list model.
// Honours WS2811_GRB_ORDER_EN to pick the expected per-pixel byte order.
module tb_ws2811_frame_streamer;

  localparam int NL   = 2;
  localparam int NBIT = 24 * NL;
  localparam int GAP  = 2600;
  localparam int BND  = NBIT * 25 + GAP + 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] frame_base;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        busy;
  logic        frame_done;

  ws2811_frame_streamer #(
    .NUM_LEDS(NL), .ADDR_W(12), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .frame_base(frame_base), .ram_addr(ram_addr),
    .ram_data(ram_data), .bit_out(bit_out),
    .bit_valid(bit_valid), .bit_ready(bit_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:4095];
  always @(posedge clk) ram_data <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_xfer = 0;
  int n_done = 0;
  int last_xfer = 0;
  int done_cyc = 0;
  bit bits_q [$];

  always @(negedge clk) begin
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bit_valid && bit_ready) begin
      bits_q.push_back(bit_out);
      n_xfer++;
      last_xfer = cyc;
    end
  end

  int rdy_mode = 0;
  int rdy_per = 20;
  initial begin
    int k = 0;
    bit_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      unique case (rdy_mode)
        0:       bit_ready = (k % rdy_per) == 0;
        1:       bit_ready = 1'b1;
        default: bit_ready = 1'($urandom % 2);
      endcase
      k++;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  int offs [3];
  logic [NBIT-1:0] exp_vec;
  logic [11:0] first_addr;
  int x0, d0;

  // Reference: byte list in wire order, then flattened MSB-first.
  task automatic build_model(input logic [11:0] base);
    exp_vec = '0;
    for (int p = 0; p < NL; p++)
      for (int s = 0; s < 3; s++) begin
        logic [11:0] a;
        a = base + 12'(3 * p + offs[s]);
        exp_vec = {exp_vec[NBIT-9:0], mem[a]};
      end
    first_addr = base + 12'(offs[0]);
  endtask

  task automatic launch(input logic [11:0] base);
    build_model(base);
    x0 = n_xfer;
    d0 = n_done;
    @(posedge clk);
    #1;
    start = 1'b1;
    frame_base = base;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_addr", ram_addr, first_addr);
    check("busy_c1", busy, 1);
    @(posedge clk);
    #1;
    check("valid_c2", bit_valid, 0);
    @(posedge clk);
    #1;
    check("valid_c3", bit_valid, 1);
    check("msb_c3", bit_out, exp_vec[NBIT-1]);
  endtask

  task automatic finish_frame(input bit poke);
    int t;
    bit done;
    int viol;
    int got_n;
    logic [NBIT-1:0] got_vec;
    t = 0;
    done = 0;
    viol = 0;
    while (t < BND) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      t++;
      if (n_done != d0) begin
        done = 1;
        break;
      end
      if (n_xfer - x0 >= NBIT && bit_valid) viol++;
      if (poke && (t == 30 ||
          (n_xfer - x0 == NBIT && cyc - last_xfer == 50))) begin
        start = 1'b1;
        frame_base = 12'($urandom);
      end
    end
    got_n = n_xfer - x0;
    got_vec = '0;
    for (int i = 0; i < NBIT && i < got_n; i++)
      got_vec = {got_vec[NBIT-2:0], bits_q[x0 + i]};
    check("done_seen", done, 1);
    check("bit_count", got_n, NBIT);
    check("bits", got_vec, exp_vec);
    check("gap_len", done_cyc - last_xfer, GAP);
    check("done_count", n_done - d0, 1);
    check("valid_in_gap", viol, 0);
    check("busy_after", busy, 0);
    check("valid_after", bit_valid, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
`ifdef WS2811_GRB_ORDER_EN
    offs = '{1, 0, 2};
`else
    offs = '{0, 1, 2};
`endif
    fill_random();
    rst = 1'b1;
    start = 1'b0;
    frame_base = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_bit", bit_out, 0);

    mem[12'h010] = 8'hA5; mem[12'h011] = 8'h3C;
    mem[12'h012] = 8'hFF; mem[12'h013] = 8'h00;
    mem[12'h014] = 8'h81; mem[12'h015] = 8'h7E;
    rdy_mode = 0;
    rdy_per = 20;
    launch(12'h010);
    finish_frame(0);

    rdy_mode = 1;
    launch(12'h010);
    finish_frame(1);

    fill_random();
    rdy_mode = 2;
    launch(12'hFFE);
    finish_frame(0);

    rdy_mode = 0;
    rdy_per = 3;
    launch(12'($urandom));
    begin
      int t = 0;
      while (n_xfer - x0 < 10 && t < 400) begin
        @(posedge clk);
        t++;
      end
      check("reached_10", n_xfer - x0 >= 10, 1);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", frame_done, 0);
    launch(12'($urandom));
    finish_frame(0);

    for (int f = 0; f < 3; f++) begin
      fill_random();
      rdy_mode = int'($urandom_range(0, 2));
      rdy_per = int'($urandom_range(3, 20));
      launch(12'($urandom));
      finish_frame(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
